// File: rtl/pb_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_conditioner_pkg
//  Description : Shared types and helpers for the pushbutton/switch
//                conditioner. It provides the channel state encoding and the
//                counter-width calculation.
//  Revision    : 1.0  initial release
// ============================================================================
package pb_conditioner_pkg;

    // Channel state of one pushbutton. The encodings are fixed so that the
    // state can be read back unambiguously in a waveform.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } ch_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The extra bit keeps a terminal count from colliding with a
    // power-of-two boundary, so the counter can never wrap.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage : pb_conditioner_pkg
`default_nettype wire

// File: rtl/pb_conditioner_db_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pb_conditioner_db_sync
//  Description : Synchroniser and debouncer for one input bit. It uses a
//                two-flop synchroniser. An optional inversion maps the
//                synchronised value to an active-high level. A level is
//                accepted only after DB_CYCLES consecutive samples that
//                differ from the current accepted level.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                i_raw    - raw asynchronous input
//                o_level  - debounced, polarity-normalised level
//  Revision    : 1.0  initial release
// ============================================================================
module pb_conditioner_db_sync
    import pb_conditioner_pkg::*;
#(
    parameter int DB_CYCLES = 500_000,
    parameter bit INVERT    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = cnt_width(DB_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          w_norm;

    // On reset, the synchroniser flops load the raw "released" level. This
    // prevents a spurious transition when reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= INVERT;
            r_sync2 <= INVERT;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_norm = r_sync2 ^ INVERT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            o_level <= 1'b0;
        end else if (w_norm == o_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            // This sample is the DB_CYCLES-th consecutive differing sample.
            o_level <= w_norm;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : pb_conditioner_db_sync
`default_nettype wire

// File: rtl/pb_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : pb_conditioner
//  Description : Conditions the board pushbuttons and slide switches for the
//                clock top. Each button is synchronised and debounced. Each
//                button produces press/release pulses and step pulses, with
//                optional auto-repeat while the button is held. Each switch
//                is synchronised and debounced to a clean level.
//  Ports       : M_CLOCK    - system clock (rising edge)
//                M_RESET    - synchronous active-high reset
//                IO_PB      - raw pushbuttons
//                IO_DSW     - raw slide switches
//                pb_level   - debounced button state, 1 = pressed
//                pb_press   - 1-cycle pulse on accepted press
//                pb_release - 1-cycle pulse on accepted release
//                pb_step    - 1-cycle pulse on press and on each repeat
//                sw_level   - debounced switch levels, 1 = up
//  Revision    : 1.0  initial release
// ============================================================================
module pb_conditioner
    import pb_conditioner_pkg::*;
#(
    parameter int              N_PB         = 4,
    parameter int              N_SW         = 8,
    parameter int              PB_ACT_LOW   = 1,
    parameter int              DB_CYCLES    = 500_000,
    parameter int              REPEAT_DELAY = 25_000_000,
    parameter int              REPEAT_RATE  = 5_000_000,
    parameter logic [N_PB-1:0] REPEAT_MASK  = '1
) (
    input  logic            M_CLOCK,
    input  logic            M_RESET,
    input  logic [N_PB-1:0] IO_PB,
    input  logic [N_SW-1:0] IO_DSW,
    output logic [N_PB-1:0] pb_level,
    output logic [N_PB-1:0] pb_press,
    output logic [N_PB-1:0] pb_release,
    output logic [N_PB-1:0] pb_step,
    output logic [N_SW-1:0] sw_level
);

    localparam int CW = cnt_width(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE));

    logic [N_PB-1:0] w_pb_db;
    logic [N_SW-1:0] w_sw_db;

    generate
        for (genvar gi = 0; gi < N_PB; gi++) begin : g_pb_db
            pb_conditioner_db_sync #(
                .DB_CYCLES (DB_CYCLES),
                .INVERT    (PB_ACT_LOW != 0)
            ) u_db (
                .clk     (M_CLOCK),
                .rst     (M_RESET),
                .i_raw   (IO_PB[gi]),
                .o_level (w_pb_db[gi])
            );
        end

        for (genvar gs = 0; gs < N_SW; gs++) begin : g_sw_db
            pb_conditioner_db_sync #(
                .DB_CYCLES (DB_CYCLES),
                .INVERT    (1'b0)
            ) u_db (
                .clk     (M_CLOCK),
                .rst     (M_RESET),
                .i_raw   (IO_DSW[gs]),
                .o_level (w_sw_db[gs])
            );
        end
    endgenerate

    // The switch levels get one register stage so that they have the same
    // latency as the button outputs.
    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            sw_level <= '0;
        end else begin
            sw_level <= w_sw_db;
        end
    end

    generate
        for (genvar gc = 0; gc < N_PB; gc++) begin : g_ch
            ch_state_t     r_state;
            logic [CW-1:0] r_rep_cnt;
            logic          r_level;
            logic          r_press;
            logic          r_release;
            logic          r_step;

            // The repeat counter counts down to zero. A step is issued on the
            // cycle in which the counter reaches zero. The debounced level
            // register and the state change together, so pb_level rises in
            // the same cycle as pb_press.
            always_ff @(posedge M_CLOCK) begin
                if (M_RESET) begin
                    r_state   <= ST_IDLE;
                    r_rep_cnt <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_step    <= 1'b0;
                end else begin
                    r_level   <= w_pb_db[gc];
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_step    <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            if (w_pb_db[gc]) begin
                                r_state   <= ST_HELD;
                                r_press   <= 1'b1;
                                r_step    <= 1'b1;
                                r_rep_cnt <= CW'(REPEAT_DELAY);
                            end
                        end
                        ST_HELD: begin
                            if (!w_pb_db[gc]) begin
                                r_state   <= ST_IDLE;
                                r_release <= 1'b1;
                                r_rep_cnt <= '0;
                            end else if (r_rep_cnt == CW'(1)) begin
                                if (REPEAT_MASK[gc]) begin
                                    r_state   <= ST_REPEAT;
                                    r_step    <= 1'b1;
                                    r_rep_cnt <= CW'(REPEAT_RATE);
                                end else begin
                                    // Repeat is disabled for this button.
                                    // The counter parks at zero, and the
                                    // channel stays in HELD.
                                    r_rep_cnt <= '0;
                                end
                            end else if (r_rep_cnt != '0) begin
                                r_rep_cnt <= r_rep_cnt - 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            // On release, any step that is due in the same
                            // cycle is dropped.
                            if (!w_pb_db[gc]) begin
                                r_state   <= ST_IDLE;
                                r_release <= 1'b1;
                                r_rep_cnt <= '0;
                            end else if (r_rep_cnt == CW'(1)) begin
                                r_step    <= 1'b1;
                                r_rep_cnt <= CW'(REPEAT_RATE);
                            end else begin
                                r_rep_cnt <= r_rep_cnt - 1'b1;
                            end
                        end
                        default: begin
                            r_state   <= ST_IDLE;
                            r_rep_cnt <= '0;
                        end
                    endcase
                end
            end

            assign pb_level[gc]   = r_level;
            assign pb_press[gc]   = r_press;
            assign pb_release[gc] = r_release;
            assign pb_step[gc]    = r_step;
        end
    endgenerate

endmodule : pb_conditioner
`default_nettype wire

// File: tb/tb_pb_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_conditioner
//  Description : Self-checking bench for pb_conditioner. It uses small timing
//                parameters and a window-based behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pb_conditioner;

    localparam int         DB    = 4;
    localparam int         DELAY = 20;
    localparam int         RATE  = 8;
    localparam logic [3:0] MASK  = 4'b0111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] io_pb = 4'hF;
    logic [7:0] io_dsw = 8'h00;
    logic [3:0] pb_level, pb_press, pb_release, pb_step;
    logic [7:0] sw_level;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pb_conditioner #(
        .N_PB         (4),
        .N_SW         (8),
        .PB_ACT_LOW   (1),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE),
        .REPEAT_MASK  (MASK)
    ) dut (
        .M_CLOCK    (clk),
        .M_RESET    (rst),
        .IO_PB      (io_pb),
        .IO_DSW     (io_dsw),
        .pb_level   (pb_level),
        .pb_press   (pb_press),
        .pb_release (pb_release),
        .pb_step    (pb_step),
        .sw_level   (sw_level)
    );

    // Reference model. For each input, a level flips once the last DB
    // synchronised samples all differ from the accepted level. A synchronised
    // sample lags the raw input by two edges. The outputs appear one edge
    // after acceptance. Steps are issued at hold ages 0, DELAY, DELAY+RATE,
    // and so on, counted from the press.
    logic [DB:0] m_hist [12];
    logic [11:0] m_acc;
    int          m_press_t [4];
    int          m_cyc = 0;
    logic [3:0]  e_level, e_press, e_release, e_step;
    logic [7:0]  e_sw;

    task automatic model_edge(input logic r, input logic [3:0] pb, input logic [7:0] sw);
        logic [11:0] norm;
        logic [11:0] nout;
        bit          all_diff;
        int          age;
        norm = {sw, ~pb};
        nout = '0;
        if (r) begin
            for (int i = 0; i < 12; i++) m_hist[i] = '0;
            m_acc = '0;
            e_level = '0; e_press = '0; e_release = '0; e_step = '0; e_sw = '0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DB; k++)
                    if (m_hist[i][k] == m_acc[i]) all_diff = 1'b0;
                nout[i] = m_acc[i];
                if (all_diff) m_acc[i] = ~m_acc[i];
                m_hist[i] = {m_hist[i][DB-1:0], norm[i]};
            end
            for (int b = 0; b < 4; b++) begin
                e_press[b]   = nout[b] & ~e_level[b];
                e_release[b] = ~nout[b] & e_level[b];
                if (e_press[b]) m_press_t[b] = m_cyc;
                age = m_cyc - m_press_t[b];
                e_step[b] = nout[b] && (age == 0 ||
                            (MASK[b] && age >= DELAY && ((age - DELAY) % RATE) == 0));
                e_level[b] = nout[b];
            end
            e_sw = nout[11:4];
        end
        m_cyc++;
    endtask

    task automatic tick(input logic r, input logic [3:0] pb, input logic [7:0] sw);
        @(negedge clk);
        rst = r; io_pb = pb; io_dsw = sw;
        @(posedge clk);
        model_edge(r, pb, sw);
        #1;
    endtask

    task automatic test_reset();
        for (int t = 0; t < 8; t++) begin
            tick(t < 3, 4'hF, 8'h00);
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !== 24'h0) begin
                n_fail++;
                $display("FAIL reset t=%0d got %h exp 000000", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level});
            end
        end
    endtask

    task automatic test_press();
        int press_t = -1;
        int step_t  = -1;
        for (int t = 0; t < 28; t++) begin
            tick(1'b0, (t < 16) ? 4'hE : 4'hF, 8'h00);
            if (pb_press[0] && press_t < 0) press_t = t;
            if (pb_step[0] && step_t < 0) step_t = t;
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !==
                {e_level, e_press, e_release, e_step, e_sw}) begin
                n_fail++;
                $display("FAIL press t=%0d got %h exp %h", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level},
                         {e_level, e_press, e_release, e_step, e_sw});
            end
        end
        n_cmp++;
        if (press_t != 6 || step_t != 6) begin
            n_fail++;
            $display("FAIL press_latency got press@%0d step@%0d exp 6/6", press_t, step_t);
        end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        for (int t = 0; t < 14; t++) begin
            tick(1'b0, (t < 3) ? 4'hD : 4'hF, 8'h00);
            seen = seen | (|{pb_level, pb_press, pb_release, pb_step});
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !==
                {e_level, e_press, e_release, e_step, e_sw}) begin
                n_fail++;
                $display("FAIL glitch t=%0d got %h exp %h", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level},
                         {e_level, e_press, e_release, e_step, e_sw});
            end
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_visible got %b exp 0", seen);
        end
    endtask

    task automatic test_repeat();
        int steps[$];
        int rel_t = -1;
        int exp_steps[6] = '{6, 26, 34, 42, 50, 58};
        for (int t = 0; t < 74; t++) begin
            tick(1'b0, (t < 60) ? 4'hB : 4'hF, 8'h00);
            if (pb_step[2]) steps.push_back(t);
            if (pb_release[2] && rel_t < 0) rel_t = t;
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !==
                {e_level, e_press, e_release, e_step, e_sw}) begin
                n_fail++;
                $display("FAIL repeat t=%0d got %h exp %h", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level},
                         {e_level, e_press, e_release, e_step, e_sw});
            end
        end
        n_cmp++;
        if (steps.size() != 6) begin
            n_fail++;
            $display("FAIL repeat_count got %0d exp 6", steps.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (steps[i] != exp_steps[i]) begin
                    n_fail++;
                    $display("FAIL repeat_step%0d got %0d exp %0d", i, steps[i], exp_steps[i]);
                end
            end
        end
        n_cmp++;
        if (rel_t != 66) begin
            n_fail++;
            $display("FAIL repeat_release got %0d exp 66", rel_t);
        end
    endtask

    task automatic test_mask();
        int nsteps = 0;
        int first  = -1;
        for (int t = 0; t < 74; t++) begin
            tick(1'b0, (t < 60) ? 4'h7 : 4'hF, 8'h00);
            if (pb_step[3]) begin
                nsteps++;
                if (first < 0) first = t;
            end
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !==
                {e_level, e_press, e_release, e_step, e_sw}) begin
                n_fail++;
                $display("FAIL mask t=%0d got %h exp %h", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level},
                         {e_level, e_press, e_release, e_step, e_sw});
            end
        end
        n_cmp++;
        if (nsteps != 1 || first != 6) begin
            n_fail++;
            $display("FAIL mask_steps got %0d@%0d exp 1@6", nsteps, first);
        end
    endtask

    task automatic test_reset_mid_press();
        int press_t = -1;
        for (int t = 0; t < 30; t++) tick(1'b0, 4'hE, 8'h00);
        for (int t = 0; t < 2; t++) begin
            tick(1'b1, 4'hE, 8'hA5);
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !== 24'h0) begin
                n_fail++;
                $display("FAIL midreset t=%0d got %h exp 000000", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level});
            end
        end
        for (int t = 0; t < 10; t++) begin
            tick(1'b0, 4'hE, 8'hA5);
            if (pb_press[0] && press_t < 0) press_t = t;
            if (t == 6) begin
                n_cmp++;
                if (sw_level !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL sw_level got %h exp a5", sw_level);
                end
            end
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !==
                {e_level, e_press, e_release, e_step, e_sw}) begin
                n_fail++;
                $display("FAIL postreset t=%0d got %h exp %h", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level},
                         {e_level, e_press, e_release, e_step, e_sw});
            end
        end
        n_cmp++;
        if (press_t != 6) begin
            n_fail++;
            $display("FAIL midreset_press got %0d exp 6", press_t);
        end
        for (int t = 0; t < 12; t++) tick(1'b0, 4'hF, 8'h00);
    endtask

    task automatic test_random();
        logic [3:0] pb = 4'hF;
        logic [7:0] sw = 8'h00;
        logic       r;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 7) == 0) pb[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) sw[$urandom_range(0, 7)] ^= 1'b1;
            r = ($urandom_range(0, 499) == 0);
            tick(r, pb, sw);
            n_cmp++;
            if ({pb_level, pb_press, pb_release, pb_step, sw_level} !==
                {e_level, e_press, e_release, e_step, e_sw}) begin
                n_fail++;
                $display("FAIL random t=%0d got %h exp %h", t,
                         {pb_level, pb_press, pb_release, pb_step, sw_level},
                         {e_level, e_press, e_release, e_step, e_sw});
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++) m_press_t[b] = 0;
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_mask();
        test_reset_mid_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pb_conditioner
`default_nettype wire
